// File: rtl/lsu_pkg.sv
// Shared LSU types: the load queue entry seen by the issue stage and the
// load pipeline state encoding.
package lsu_pkg;

    localparam int LSU_XLEN          = 32;
    localparam int LSU_ROB_TAG_WIDTH = 32;

    typedef struct packed {
        logic                         valid;
        logic                         address_valid;
        logic                         executed;
        logic [LSU_ROB_TAG_WIDTH-1:0] rob_tag;
        logic [LSU_XLEN-1:0]          address;
    } load_queue_entry;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } load_pipe_state_t;

    function automatic logic is_load_candidate(input load_queue_entry e);
        return e.valid && e.address_valid && !e.executed;
    endfunction

endpackage

// File: rtl/ldq_oldest_select.sv
// Circular priority pick: first set bit of cand scanning head, head+1, ...
// modulo LDQ_SIZE. Purely combinational.
module ldq_oldest_select #(
    parameter int LDQ_SIZE = 16,
    parameter int IDX_W    = $clog2(LDQ_SIZE)
) (
    input  logic [LDQ_SIZE-1:0] cand,
    input  logic [IDX_W-1:0]    head,
    output logic                found,
    output logic [IDX_W-1:0]    index
);

    logic [LDQ_SIZE-1:0] rot;
    logic [IDX_W-1:0]    offset;

    // rot[k] is the entry k slots past head; index arithmetic wraps naturally
    for (genvar gi = 0; gi < LDQ_SIZE; gi++) begin : g_rot
        logic [IDX_W-1:0] idx;
        assign idx     = head + IDX_W'(gi);
        assign rot[gi] = cand[idx];
    end

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = LDQ_SIZE - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
    end

    assign index = head + offset;

endmodule

// File: rtl/load_pipeline.sv
// Load issue / memory-access stage: picks the oldest ready load from the LDQ,
// issues it with a valid/ready request, and broadcasts the returned word.
module load_pipeline
    import lsu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int LDQ_SIZE      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  load_queue_entry [LDQ_SIZE-1:0]    load_queue_entries,
    input  logic [$clog2(LDQ_SIZE)-1:0]       ldq_head,
    input  logic                              flush,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [XLEN-1:0]                   mem_req_addr,
    input  logic                              mem_resp_valid,
    input  logic [XLEN-1:0]                   mem_resp_data,
    output logic                              load_executed,
    output logic [ROB_TAG_WIDTH-1:0]          load_executed_rob_tag,
    output logic                              load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0]          load_succeeded_rob_tag,
    output logic                              result_valid,
    output logic [XLEN-1:0]                   result_data,
    output logic [ROB_TAG_WIDTH-1:0]          result_rob_tag
);

    localparam int IDX_W = $clog2(LDQ_SIZE);

    load_pipe_state_t         state_q, state_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [XLEN-1:0]          addr_q, addr_d;

    logic [LDQ_SIZE-1:0] cand;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;

    for (genvar gi = 0; gi < LDQ_SIZE; gi++) begin : g_cand
        assign cand[gi] = is_load_candidate(load_queue_entries[gi]);
    end

    ldq_oldest_select #(
        .LDQ_SIZE (LDQ_SIZE),
        .IDX_W    (IDX_W)
    ) u_select (
        .cand  (cand),
        .head  (ldq_head),
        .found (sel_found),
        .index (sel_idx)
    );

    logic req_fire;
    logic resp_fire;

    assign req_fire  = (state_q == REQ)  && mem_req_ready  && !flush;
    assign resp_fire = (state_q == WAIT) && mem_resp_valid && !flush;

    // Flush wins over every transition; an accepted request still owes a
    // response, which DRAIN swallows.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (!flush && sel_found) begin
                    state_d = REQ;
                    tag_d   = ROB_TAG_WIDTH'(load_queue_entries[sel_idx].rob_tag);
                    addr_d  = XLEN'(load_queue_entries[sel_idx].address);
                end
            end
            REQ: begin
                if (flush)              state_d = mem_req_ready ? DRAIN : IDLE;
                else if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (flush)               state_d = mem_resp_valid ? IDLE : DRAIN;
                else if (mem_resp_valid) state_d = IDLE;
            end
            DRAIN: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_req_valid          = (state_q == REQ);
    assign mem_req_addr           = (state_q == REQ) ? addr_q : '0;
    assign load_executed          = req_fire;
    assign load_executed_rob_tag  = req_fire ? tag_q : '0;
    assign load_succeeded         = resp_fire;
    assign load_succeeded_rob_tag = resp_fire ? tag_q : '0;
    assign result_valid           = resp_fire;
    assign result_data            = resp_fire ? mem_resp_data : '0;
    assign result_rob_tag         = resp_fire ? tag_q : '0;

endmodule

// File: tb/tb_load_pipeline.sv
// Scoreboard bench for load_pipeline: LDQ model, memory responder, and
// monitors that pop expected issues/results as the DUT produces them.
module tb_load_pipeline;
    import lsu_pkg::*;

    logic                   clk;
    logic                   reset;
    load_queue_entry [15:0] ldq_bus;
    logic [3:0]             ldq_head;
    logic                   flush;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [31:0]            mem_req_addr;
    logic                   mem_resp_valid;
    logic [31:0]            mem_resp_data;
    logic                   load_executed;
    logic [31:0]            load_executed_rob_tag;
    logic                   load_succeeded;
    logic [31:0]            load_succeeded_rob_tag;
    logic                   result_valid;
    logic [31:0]            result_data;
    logic [31:0]            result_rob_tag;

    load_pipeline #(.XLEN(32), .ROB_TAG_WIDTH(32), .LDQ_SIZE(16)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .load_queue_entries     (ldq_bus),
        .ldq_head               (ldq_head),
        .flush                  (flush),
        .mem_req_valid          (mem_req_valid),
        .mem_req_ready          (mem_req_ready),
        .mem_req_addr           (mem_req_addr),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data),
        .load_executed          (load_executed),
        .load_executed_rob_tag  (load_executed_rob_tag),
        .load_succeeded         (load_succeeded),
        .load_succeeded_rob_tag (load_succeeded_rob_tag),
        .result_valid           (result_valid),
        .result_data            (result_data),
        .result_rob_tag         (result_rob_tag)
    );

    int checks   = 0;
    int failures = 0;

    load_queue_entry ldq [16];
    bit [255:0]      executed_tag;
    logic [63:0]     exp_issue [$];
    logic [63:0]     exp_res [$];
    int              resp_delay;
    logic            resp_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'd42) return 32'hDEADBEEF;
        return (a * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    function automatic load_queue_entry mk_entry(input logic [31:0] tag, input logic [31:0] a);
        load_queue_entry e;
        e.valid         = 1'b1;
        e.address_valid = 1'b1;
        e.executed      = 1'b0;
        e.rob_tag       = tag;
        e.address       = a;
        return e;
    endfunction

    // The LDQ marks an entry executed once its tag has been seen issuing.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ldq_bus[i]          = ldq[i];
            ldq_bus[i].executed = ldq[i].executed | executed_tag[ldq[i].rob_tag[7:0]];
        end
    end

    // Memory responder: answers each accepted request resp_delay cycles later.
    initial begin
        logic [31:0] a;
        int d;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        resp_busy      = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && mem_req_valid && mem_req_ready) begin
                resp_busy = 1'b1;
                a = mem_req_addr;
                d = resp_delay;
                repeat (d) @(posedge clk);
                #1;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_data(a);
                @(posedge clk);
                #1;
                mem_resp_valid = 1'b0;
                mem_resp_data  = '0;
                resp_busy      = 1'b0;
            end
        end
    end

    // Monitors: compare issue and writeback events against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (load_executed) begin
                    $display("issue  tag=%0d addr=%0d", load_executed_rob_tag, mem_req_addr);
                    check_val("exec_req_valid", {63'd0, mem_req_valid}, 64'd1);
                    if (exp_issue.size() == 0) begin
                        check_val("spurious_exec", 64'd1, 64'd0);
                    end else begin
                        e = exp_issue.pop_front();
                        check_val("exec_tag", {32'd0, load_executed_rob_tag}, {32'd0, e[63:32]});
                        check_val("req_addr", {32'd0, mem_req_addr}, {32'd0, e[31:0]});
                    end
                    executed_tag[load_executed_rob_tag[7:0]] = 1'b1;
                end
                if (result_valid || load_succeeded) begin
                    $display("result tag=%0d data=0x%08h", result_rob_tag, result_data);
                    check_val("succ_vs_result", {63'd0, load_succeeded}, {63'd0, result_valid});
                    if (exp_res.size() == 0) begin
                        check_val("spurious_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_res.pop_front();
                        check_val("result_tag", {32'd0, result_rob_tag}, {32'd0, e[63:32]});
                        check_val("result_data", {32'd0, result_data}, {32'd0, e[31:0]});
                        check_val("succ_tag", {32'd0, load_succeeded_rob_tag}, {32'd0, e[63:32]});
                    end
                end
            end
        end
    end

    task automatic expect_load(input logic [31:0] tag, input logic [31:0] a, input bit completes);
        exp_issue.push_back({tag, a});
        if (completes) exp_res.push_back({tag, mem_data(a)});
    endtask

    task automatic clear_ldq();
        for (int i = 0; i < 16; i++) ldq[i] = '0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            if (exp_issue.size() == 0 && exp_res.size() == 0 && !resp_busy) done = 1'b1;
        end
        check_val(name, {63'd0, done}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        reset         = 1'b0;
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        ldq_head      = '0;
        resp_delay    = 1;
        executed_tag  = '0;
        clear_ldq();
        ldq[3] = mk_entry(32'd99, 32'd77);

        // Reset held with a candidate present: everything stays at zero.
        repeat (2) @(negedge clk);
        check_val("rst_req_valid",  {63'd0, mem_req_valid}, 64'd0);
        check_val("rst_req_addr",   {32'd0, mem_req_addr}, 64'd0);
        check_val("rst_exec",       {63'd0, load_executed}, 64'd0);
        check_val("rst_exec_tag",   {32'd0, load_executed_rob_tag}, 64'd0);
        check_val("rst_succ",       {63'd0, load_succeeded}, 64'd0);
        check_val("rst_succ_tag",   {32'd0, load_succeeded_rob_tag}, 64'd0);
        check_val("rst_res_valid",  {63'd0, result_valid}, 64'd0);
        check_val("rst_res_data",   {32'd0, result_data}, 64'd0);
        check_val("rst_res_tag",    {32'd0, result_rob_tag}, 64'd0);

        @(posedge clk);
        #1;
        clear_ldq();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("idle_no_req", {63'd0, mem_req_valid}, 64'd0);
        end

        // Single load, best-case timing.
        @(posedge clk);
        #1;
        ldq[0] = mk_entry(32'd19, 32'd42);
        expect_load(32'd19, 32'd42, 1'b1);
        wait_drain("single_done");

        // Backpressure: request held stable while ready is low.
        clear_ldq();
        mem_req_ready = 1'b0;
        ldq[4] = mk_entry(32'd21, 32'd300);
        expect_load(32'd21, 32'd300, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_req_valid", {63'd0, mem_req_valid}, 64'd1);
            check_val("bp_req_addr",  {32'd0, mem_req_addr}, 64'd300);
            check_val("bp_no_exec",   {63'd0, load_executed}, 64'd0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        wait_drain("bp_done");

        // Wrap-around: head=14, entry 15 is older than entry 1.
        clear_ldq();
        ldq_head = 4'd14;
        ldq[1]  = mk_entry(32'd5, 32'd200);
        ldq[15] = mk_entry(32'd7, 32'd204);
        expect_load(32'd7, 32'd204, 1'b1);
        expect_load(32'd5, 32'd200, 1'b1);
        wait_drain("wrap_done");
        ldq_head = '0;

        // Flush while waiting for the response: it is discarded in DRAIN.
        clear_ldq();
        resp_delay = 4;
        ldq[2] = mk_entry(32'd33, 32'd100);
        expect_load(32'd33, 32'd100, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            if (exp_issue.size() == 0) seen = 1'b1;
        end
        check_val("fw_issued", {63'd0, seen}, 64'd1);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        resp_delay = 1;
        ldq[2] = '0;
        ldq[3] = mk_entry(32'd34, 32'd104);
        expect_load(32'd34, 32'd104, 1'b1);
        wait_drain("fw_done");

        // Flush during a stalled request: withdrawn next cycle, no pulses.
        clear_ldq();
        mem_req_ready = 1'b0;
        ldq[6] = mk_entry(32'd40, 32'd400);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_val("fr_req_before", {63'd0, mem_req_valid}, 64'd1);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        ldq[6] = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("fr_req_dropped", {63'd0, mem_req_valid}, 64'd0);
        end
        mem_req_ready = 1'b1;
        wait_drain("fr_done");

        check_val("issue_q_empty", 64'(exp_issue.size()), 64'd0);
        check_val("result_q_empty", 64'(exp_res.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_pipeline.md
# load_pipeline

Issue and memory-access stage directly downstream of `load_queue` in the out-of-order LSU. Each cycle it scans the load queue from head, oldest first, for an entry whose address is resolved but not yet executed. It issues that load to the data-memory port with a valid/ready handshake, then waits for the response. It reports `load_executed` / `load_succeeded` back to the load queue and broadcasts the loaded word with its ROB tag. One load is in flight at a time; loads issue speculatively, and ordering failures are detected by the load queue, not here.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `LDQ_SIZE`, 16, load queue depth (power of two)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_queue_entries`  in  `load_queue_entry [LDQ_SIZE-1:0]`  LDQ contents
- `ldq_head`  in  `$clog2(LDQ_SIZE)`  index of oldest LDQ entry
- `flush`  in  1  pipeline flush (branch mispredict / exception)
- `mem_req_valid`  out  1  memory read request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  XLEN  request address (word)
- `mem_resp_valid`  in  1  read data valid
- `mem_resp_data`  in  XLEN  read data
- `load_executed`  out  1  pulse: load issued to memory
- `load_executed_rob_tag`  out  ROB_TAG_WIDTH  tag of issued load
- `load_succeeded`  out  1  pulse: load data returned
- `load_succeeded_rob_tag`  out  ROB_TAG_WIDTH  tag of completed load
- `result_valid`  out  1  writeback broadcast valid
- `result_data`  out  XLEN  loaded word
- `result_rob_tag`  out  ROB_TAG_WIDTH  writeback tag

## Operation
- Candidate: `valid && address_valid && !executed`. Select the first candidate scanning `ldq_head`, `ldq_head+1`, … modulo `LDQ_SIZE` (wrap-around). With no candidate, remain in IDLE.
- State machine (`load_pipe_state_t`):
  - IDLE: if a candidate exists and `!flush`, latch its rob_tag and address, then go to REQ.
  - REQ: `mem_req_valid=1` with `mem_req_addr` = latched address, both held stable until `valid && ready`. On the handshake, pulse `load_executed` with the latched tag in the same cycle, then go to WAIT.
  - WAIT: on `mem_resp_valid`, drive `load_succeeded`, `result_valid`, `result_data=mem_resp_data`, and both tags = latched tag in the same cycle, then go to IDLE.
  - DRAIN: discard the next `mem_resp_valid`, then go to IDLE. No outputs.
- Flush, which takes priority over every other transition:
  - IDLE or REQ: go to IDLE; `mem_req_valid` drops in the next cycle. This is the only legal withdrawal of a request.
  - WAIT: if the response arrives in the same cycle, discard it and go to IDLE; otherwise go to DRAIN.
  - A handshake in the flush cycle of REQ counts as issued, so the machine goes to DRAIN and does not pulse `load_executed`.
- `mem_resp_valid` outside WAIT or DRAIN is ignored. Memory must respond no earlier than the cycle after acceptance.
- All loads are full XLEN words; there is no sign or size handling.

## Timing
- Reset (async, `reset=0`): state IDLE. All outputs and latched tag/address are 0.
- Best case: candidate visible in cycle N → REQ at N+1 → handshake at N+1 → response at N+2. Result is broadcast combinationally in N+2; the next issue is possible at N+3.
- All outputs are decoded from registered state and latches, except the handshake-qualified `load_executed` and the response-qualified WAIT outputs, which are combinational.
- The LDQ sets `executed` on the handshake edge, so the same entry is never re-selected.
- `ldq_head` changes and wrap-around only affect selection made in IDLE. Latched values are unaffected.

## Structure
- `lsu_pkg` holds `load_queue_entry` (existing) and a new `load_pipe_state_t` enum {IDLE, REQ, WAIT, DRAIN}.
- Sub-module `ldq_oldest_select`: combinational circular priority pick from head. Outputs `found` and `index`.

## Test plan
- Reset: hold `reset=0` → every output 0. Release, with all entries invalid → `mem_req_valid` stays 0.
- Single load:
  - Stimulus: entry 0 `{valid,address_valid}`, tag 19, address 42; `mem_req_ready=1`; response 0xDEADBEEF two cycles later.
  - Required: `mem_req_addr=42`; `load_executed` with tag 19 for one cycle; `load_succeeded` and `result_valid` with data 0xDEADBEEF and tag 19.
- Backpressure: `mem_req_ready=0` for 3 cycles → `mem_req_valid` and `mem_req_addr` stable, no `load_executed` until ready=1.
- Wrap-around:
  - Stimulus: head=14; candidates at entries 1 (tag 5) and 15 (tag 7).
  - Required: tag 7 issues first, then tag 5.
- Flush in WAIT: assert flush before the response → response discarded, no `load_succeeded` or `result_valid`. The next candidate issues after DRAIN.
- Flush during REQ with `ready=0` → `mem_req_valid` drops the next cycle, no pulses, back to IDLE.
